// File: rtl/w5300_socket_seq.sv
// W5300 socket command sequencer: CONF / TX / RX register-op sequences for one socket.
// Optional poll timeout is enabled by defining W5300_SEQ_TIMEOUT_EN.
module w5300_socket_seq #(
    parameter int          SOCKETS  = 8,
    parameter logic [15:0] SRC_PORT = 16'd7000,
    parameter logic [15:0] MSS      = 16'h05C0,
    parameter int          POLL_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd,
    input  logic [2:0]  sock_sel,
    input  logic [31:0] dst_ip,
    input  logic [15:0] dst_port,
    input  logic [15:0] tx_len,
    output logic        cmd_ready,
    output logic        op_valid,
    output logic [26:0] op_word,
    input  logic        op_ready,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    input  logic [15:0] tx_data,
    output logic        tx_data_req,
    output logic        rx_data_valid,
    output logic [15:0] rx_data,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, NEXT, FIN} state_t;
    typedef enum logic [4:0] {
        S_MR, S_IMR, S_PORTR, S_MSSR, S_CRC, S_SSR,
        S_FSR0, S_FSR2, S_DIPR0, S_DIPR2, S_DPORTR, S_TXF, S_WRSR0, S_WRSR2, S_CRT,
        S_RSR0, S_RSR2, S_RXF, S_CRR
    } step_t;

    state_t      state, state_n;
    step_t       step, step_n;
    logic [1:0]  cmd_l;
    logic [2:0]  sock_l;
    logic [31:0] ip_l;
    logic [15:0] port_l, len_l, words, words_ld, rdat;
    logic        hi_l, err_r;
    logic        load_words, dec_words, err_set, err_val, bad;
    logic        rd;
    logic [9:0]  base, addr;
    logic [15:0] wd;
    logic [16:0] cnt17;
    logic [17:0] rx_words;
    logic [16:0] tx_words;

`ifdef W5300_SEQ_TIMEOUT_EN
    logic [15:0] poll_cnt;
    logic        poll_inc, poll_clr, poll_last;
    assign poll_last = (poll_cnt == 16'(POLL_MAX - 1));
`endif

    // Register-op decode for the current step
    always_comb begin
        rd   = 1'b0;
        base = 10'h200;
        wd   = 16'h0000;
        case (step)
            S_MR:     begin base = 10'h200; wd = 16'h0002; end
            S_IMR:    begin base = 10'h204; wd = 16'h0140; end
            S_PORTR:  begin base = 10'h20A; wd = SRC_PORT; end
            S_MSSR:   begin base = 10'h218; wd = MSS; end
            S_CRC:    begin base = 10'h202; wd = 16'h0001; end
            S_SSR:    begin base = 10'h208; rd = 1'b1; end
            S_FSR0:   begin base = 10'h224; rd = 1'b1; end
            S_FSR2:   begin base = 10'h226; rd = 1'b1; end
            S_DIPR0:  begin base = 10'h214; wd = ip_l[31:16]; end
            S_DIPR2:  begin base = 10'h216; wd = ip_l[15:0]; end
            S_DPORTR: begin base = 10'h212; wd = port_l; end
            S_TXF:    begin base = 10'h22E; wd = tx_data; end
            S_WRSR0:  begin base = 10'h220; wd = 16'h0000; end
            S_WRSR2:  begin base = 10'h222; wd = len_l; end
            S_CRT:    begin base = 10'h202; wd = 16'h0020; end
            S_RSR0:   begin base = 10'h228; rd = 1'b1; end
            S_RSR2:   begin base = 10'h22A; rd = 1'b1; end
            S_RXF:    begin base = 10'h230; rd = 1'b1; end
            S_CRR:    begin base = 10'h202; wd = 16'h0040; end
            default:  begin base = 10'h200; wd = 16'h0000; end
        endcase
    end

    assign addr          = base + {1'b0, sock_l, 6'b0};
    assign op_valid      = (state == ISSUE);
    assign op_word       = op_valid ? {rd, addr, (rd ? 16'hFFFF : wd)} : '1;
    assign cmd_ready     = (state == IDLE);
    assign done          = (state == FIN);
    assign err           = err_r;
    assign tx_data_req   = op_valid && op_ready && (step == S_TXF);
    assign rx_data_valid = (state == WAIT_RD) && rd_valid && (step == S_RXF);
    assign rx_data       = rx_data_valid ? rd_data : '0;

    assign cnt17    = {hi_l, rdat};
    assign rx_words = {1'b0, cnt17} + 18'd1;
    assign tx_words = {1'b0, len_l} + 17'd1;

    always_comb begin
        state_n    = state;
        step_n     = step;
        load_words = 1'b0;
        words_ld   = '0;
        dec_words  = 1'b0;
        err_set    = 1'b0;
        err_val    = 1'b0;
        bad        = 1'b0;
`ifdef W5300_SEQ_TIMEOUT_EN
        poll_inc   = 1'b0;
        poll_clr   = 1'b0;
`endif
        case (state)
            IDLE: if (cmd_valid) begin
                bad     = (int'(sock_sel) >= SOCKETS) || (cmd == 2'd3) ||
                          ((cmd == 2'd1) && (tx_len == 16'd0));
                err_set = 1'b1;
                err_val = bad;
`ifdef W5300_SEQ_TIMEOUT_EN
                poll_clr = 1'b1;
`endif
                state_n = bad ? FIN : ISSUE;
                step_n  = (cmd == 2'd0) ? S_MR : (cmd == 2'd1) ? S_FSR0 : S_RSR0;
            end
            ISSUE:   if (op_ready) state_n = rd ? WAIT_RD : NEXT;
            WAIT_RD: if (rd_valid) state_n = NEXT;
            NEXT: begin
                state_n = ISSUE;
                case (step)
                    S_MR:     step_n = S_IMR;
                    S_IMR:    step_n = S_PORTR;
                    S_PORTR:  step_n = S_MSSR;
                    S_MSSR:   step_n = S_CRC;
                    S_CRC:    step_n = S_SSR;
                    S_SSR: if (rdat[7:0] == 8'h22) state_n = FIN;
`ifdef W5300_SEQ_TIMEOUT_EN
                    else if (poll_last) begin state_n = FIN; err_set = 1'b1; err_val = 1'b1; end
                    else poll_inc = 1'b1;
`endif
                    S_FSR0:   step_n = S_FSR2;
                    S_FSR2: if (cnt17 < {1'b0, len_l}) begin
                        step_n = S_FSR0;
`ifdef W5300_SEQ_TIMEOUT_EN
                        if (poll_last) begin state_n = FIN; err_set = 1'b1; err_val = 1'b1; end
                        else poll_inc = 1'b1;
`endif
                    end else step_n = S_DIPR0;
                    S_DIPR0:  step_n = S_DIPR2;
                    S_DIPR2:  step_n = S_DPORTR;
                    S_DPORTR: begin step_n = S_TXF; load_words = 1'b1; words_ld = tx_words[16:1]; end
                    S_TXF: begin
                        dec_words = 1'b1;
                        if (words == 16'd1) step_n = S_WRSR0;
                    end
                    S_WRSR0:  step_n = S_WRSR2;
                    S_WRSR2:  step_n = S_CRT;
                    S_CRT:    state_n = FIN;
                    S_RSR0:   step_n = S_RSR2;
                    S_RSR2: if (cnt17 == 17'd0) state_n = FIN;
                    else begin step_n = S_RXF; load_words = 1'b1; words_ld = rx_words[16:1]; end
                    S_RXF: begin
                        dec_words = 1'b1;
                        if (words == 16'd1) step_n = S_CRR;
                    end
                    S_CRR:    state_n = FIN;
                    default:  state_n = FIN;
                endcase
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= S_MR;
        end else begin
            state <= state_n;
            step  <= step_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_l  <= '0;
            sock_l <= '0;
            ip_l   <= '0;
            port_l <= '0;
            len_l  <= '0;
            words  <= '0;
            rdat   <= '0;
            hi_l   <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                cmd_l  <= cmd;
                sock_l <= sock_sel;
                ip_l   <= dst_ip;
                port_l <= dst_port;
                len_l  <= tx_len;
            end
            if (state == WAIT_RD && rd_valid) begin
                rdat <= rd_data;
                if (step == S_FSR0 || step == S_RSR0) hi_l <= rd_data[0];
            end
            if (load_words)     words <= words_ld;
            else if (dec_words) words <= words - 16'd1;
            if (err_set) err_r <= err_val;
        end
    end

`ifdef W5300_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        poll_cnt <= '0;
        else if (poll_clr) poll_cnt <= '0;
        else if (poll_inc) poll_cnt <= poll_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_w5300_socket_seq.sv
// Directed self-checking bench for w5300_socket_seq with a scripted bus responder.
module tb_w5300_socket_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = '0;
    logic [2:0]  sock_sel = '0;
    logic [31:0] dst_ip = '0;
    logic [15:0] dst_port = '0;
    logic [15:0] tx_len = '0;
    logic        cmd_ready, op_valid, tx_data_req, rx_data_valid, done, err;
    logic [26:0] op_word;
    logic        op_ready = 1'b1;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_data = '0;
    logic [15:0] tx_data = 16'hA000;
    logic [15:0] rx_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] resp[$];
    logic [26:0] ops[$];
    logic [26:0] expq[$];
    logic [15:0] rxq[$];
    int          txreq_cnt = 0;
    logic        pend = 1'b0;
    logic        bump = 1'b0;
    logic        got_done;

    w5300_socket_seq #(.SOCKETS(4), .POLL_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .sock_sel(sock_sel),
        .dst_ip(dst_ip), .dst_port(dst_port), .tx_len(tx_len), .cmd_ready(cmd_ready),
        .op_valid(op_valid), .op_word(op_word), .op_ready(op_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .tx_data(tx_data), .tx_data_req(tx_data_req),
        .rx_data_valid(rx_data_valid), .rx_data(rx_data), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] wr(input logic [9:0] a, input logic [15:0] d);
        return {1'b0, a, d};
    endfunction

    function automatic logic [26:0] rdop(input logic [9:0] a);
        return {1'b1, a, 16'hFFFF};
    endfunction

    // Bus responder: logs every handshake, answers reads one cycle later from resp
    initial begin
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (bump) begin tx_data = tx_data + 16'd1; bump = 1'b0; end
            if (pend) begin
                rd_valid = 1'b1;
                rd_data  = (resp.size() > 0) ? resp.pop_front() : 16'h0000;
                pend     = 1'b0;
            end
            #1;
            if (!rst_n) begin
                pend     = 1'b0;
                rd_valid = 1'b0;
            end else begin
                if (rx_data_valid) rxq.push_back(rx_data);
                if (op_valid && op_ready) begin
                    ops.push_back(op_word);
                    if (op_word[26]) pend = 1'b1;
                end
                if (tx_data_req) begin txreq_cnt++; bump = 1'b1; end
            end
        end
    end

    task automatic run(input logic [1:0] c, input logic [2:0] s, input logic [31:0] ip,
                       input logic [15:0] p, input logic [15:0] l);
        ops.delete();
        rxq.delete();
        txreq_cnt = 0;
        @(negedge clk);
        cmd = c; sock_sel = s; dst_ip = ip; dst_port = p; tx_len = l;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            #2;
            if (done) begin got_done = 1'b1; break; end
            @(negedge clk);
        end
        chk("done_seen", got_done, 1);
        @(negedge clk);
        #2;
    endtask

    task automatic check_ops(input string tag);
        chk({tag, "_nops"}, ops.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_op%0d", tag, i), (i < ops.size()) ? ops[i] : 27'h0, expq[i]);
    endtask

    initial begin
        #22;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_word", op_word, 27'h7FFFFFF);
        chk("rst_done_err", {done, err, tx_data_req, rx_data_valid}, 0);
        chk("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        resp = '{16'h0000, 16'h0022};
        run(2'd0, 3'd2, 32'h0, 16'h0, 16'h0);
        expq = '{wr(10'h280, 16'h0002), wr(10'h284, 16'h0140), wr(10'h28A, 16'h1B58),
                 wr(10'h298, 16'h05C0), wr(10'h282, 16'h0001), rdop(10'h288), rdop(10'h288)};
        check_ops("conf");
        chk("conf_err", err, 0);

        resp = '{16'h0001, 16'h0000};
        tx_data = 16'hA000;
        run(2'd1, 3'd0, 32'hC0A80102, 16'h1F90, 16'd5);
        expq = '{rdop(10'h224), rdop(10'h226), wr(10'h214, 16'hC0A8), wr(10'h216, 16'h0102),
                 wr(10'h212, 16'h1F90), wr(10'h22E, 16'hA000), wr(10'h22E, 16'hA001),
                 wr(10'h22E, 16'hA002), wr(10'h220, 16'h0000), wr(10'h222, 16'h0005),
                 wr(10'h202, 16'h0020)};
        check_ops("tx5");
        chk("tx5_req", txreq_cnt, 3);
        chk("tx5_err", err, 0);

        resp = '{16'h0000, 16'h0010, 16'h0000, 16'h0400};
        run(2'd1, 3'd1, 32'h01020304, 16'h0050, 16'd100);
        chk("tx100_nops", ops.size(), 60);
        chk("tx100_fsr2b", ops[3], rdop(10'h266));
        chk("tx100_dipr0", ops[4], wr(10'h254, 16'h0102));
        chk("tx100_req", txreq_cnt, 50);

        resp = '{16'h0000, 16'h0004, 16'h1111, 16'h2222};
        run(2'd2, 3'd0, 32'h0, 16'h0, 16'h0);
        expq = '{rdop(10'h228), rdop(10'h22A), rdop(10'h230), rdop(10'h230),
                 wr(10'h202, 16'h0040)};
        check_ops("rx4");
        chk("rx4_cnt", rxq.size(), 2);
        chk("rx4_w0", (rxq.size() > 0) ? rxq[0] : 16'h0, 16'h1111);
        chk("rx4_w1", (rxq.size() > 1) ? rxq[1] : 16'h0, 16'h2222);

        resp = '{16'h0000, 16'h0000};
        run(2'd2, 3'd3, 32'h0, 16'h0, 16'h0);
        expq = '{rdop(10'h2E8), rdop(10'h2EA)};
        check_ops("rx0");
        chk("rx0_err", err, 0);

        run(2'd1, 3'd7, 32'h0, 16'h0, 16'd4);
        chk("badsock_nops", ops.size(), 0);
        chk("badsock_err", err, 1);
        run(2'd3, 3'd0, 32'h0, 16'h0, 16'd4);
        chk("badcmd_err", {ops.size() == 0, err}, 2'b11);
        run(2'd1, 3'd0, 32'h0, 16'h0, 16'd0);
        chk("txlen0_err", {ops.size() == 0, err}, 2'b11);

        resp = '{16'h0001, 16'h0000};
        @(negedge clk);
        cmd = 2'd1; sock_sel = 3'd0; tx_len = 16'd10; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #2;
            if (op_valid && op_word[25:16] == 10'h22E) begin got_done = 1'b1; break; end
            @(negedge clk);
        end
        chk("mid_txf_seen", got_done, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_op_valid", op_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_op_word", op_word, 27'h7FFFFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resp.delete();

`ifdef W5300_SEQ_TIMEOUT_EN
        resp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run(2'd0, 3'd1, 32'h0, 16'h0, 16'h0);
        expq = '{wr(10'h240, 16'h0002), wr(10'h244, 16'h0140), wr(10'h24A, 16'h1B58),
                 wr(10'h258, 16'h05C0), wr(10'h242, 16'h0001), rdop(10'h248),
                 rdop(10'h248), rdop(10'h248)};
        check_ops("tmo");
        chk("tmo_err", err, 1);
        resp.delete();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/w5300_socket_seq.md
W5300_SOCKET_SEQ -- requirements
Module: w5300_socket_seq

Interface
REQ-001 SHALL have parameter SOCKETS, default 8: number of addressable sockets, 1..8.
REQ-002 SHALL have parameter SRC_PORT, default 7000: value written to Sn_PORTR.
REQ-003 SHALL have parameter MSS, default 16'h05C0: value written to Sn_MSSR.
REQ-004 SHALL have parameter POLL_MAX, default 255: Sn_SSR poll limit.
REQ-005 SHALL have ports, one per line, as follows:
- clk  in  1  clock; one clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd  in  2  command: 0 CONF, 1 TX, 2 RX, 3 reserved.
- sock_sel  in  3  socket index.
- dst_ip  in  32  TX destination IP.
- dst_port  in  16  TX destination port.
- tx_len  in  16  TX byte count.
- cmd_ready  out  1  idle; command accepted on cmd_valid&cmd_ready.
- op_valid  out  1  bus op pending.
- op_word  out  27  bus op as {rd(1), addr(10), wdata(16)}; rd=1 is read.
- op_ready  in  1  bus engine accepts op.
- rd_valid  in  1  read data return.
- rd_data  in  16  read data.
- tx_data  in  16  payload word.
- tx_data_req  out  1  payload word consumed.
- rx_data_valid  out  1  received word strobe.
- rx_data  out  16  received word.
- done  out  1  command-complete pulse.
- err  out  1  error flag, valid with done.

Function
REQ-006 SHALL latch cmd, sock_sel, dst_ip, dst_port and tx_len on command accept; inputs are ignored until done.
REQ-007 SHALL compute address = base + 10'h040*sock_sel_latched; bases: MR 200, CR 202, IMR 204, SSR 208, PORTR 20A, DPORTR 212, DIPR0 214, DIPR2 216, MSSR 218, WRSR0 220, WRSR2 222, FSR0 224, FSR2 226, TxFIFO 22E, RSR0 228, RSR2 22A, RxFIFO 230.
REQ-008 SHALL use FSM states IDLE, ISSUE, WAIT_RD, NEXT, FIN.
- IDLE -> ISSUE on accept.
- ISSUE -> WAIT_RD on a read handshake; ISSUE -> NEXT on a write handshake.
- WAIT_RD -> NEXT on rd_valid.
- NEXT -> ISSUE (next step) or FIN.
- FIN -> IDLE after 1 cycle.
REQ-009 SHALL hold op_valid and op_word stable from assertion until op_valid&op_ready; one op is outstanding at a time; reads drive wdata=16'hFFFF.
REQ-010 SHALL run CONF as:
- W MR=0002, W IMR=0140, W PORTR=SRC_PORT, W MSSR=MSS, W CR=0001.
- Then R SSR repeatedly until rd_data[7:0]==8'h22.
REQ-011 SHALL run TX as:
- R FSR0, R FSR2; free={FSR0[0],FSR2}.
- If free<tx_len, repeat both FSR reads.
- Else W DIPR0=dst_ip[31:16], W DIPR2=dst_ip[15:0], W DPORTR=dst_port.
- Then ceil(tx_len/2) W TxFIFO=tx_data.
- Then W WRSR0=0000, W WRSR2=tx_len, W CR=0020.
REQ-012 SHALL pulse tx_data_req for 1 cycle on each TxFIFO write handshake; tx_data is sampled combinationally into op_word while that op is pending.
REQ-013 SHALL run RX as:
- R RSR0, R RSR2; n={RSR0[0],RSR2}.
- If n==0, FIN with err=0.
- Else ceil(n/2) R RxFIFO, then W CR=0040.
REQ-014 SHALL forward each RxFIFO rd_data to rx_data with a 1-cycle rx_data_valid pulse on the rd_valid cycle.
REQ-015 SHALL pulse done for 1 cycle in FIN; err=1 when sock_sel>=SOCKETS, cmd==3, or TX with tx_len==0 (each of these goes straight to FIN with zero bus ops), or on poll timeout; else err=0; err holds until the next accept.
REQ-016 SHALL ignore rd_valid outside WAIT_RD and ignore op_ready while op_valid=0.
REQ-017 SHALL use a 16-bit word counter and round odd byte counts up (tx_len=16'hFFFF gives 32768 words).

Reset
REQ-018 SHALL on rst_n low, including mid-command, enter IDLE asynchronously, abandon the outstanding op, and clear all counters.
REQ-019 SHALL reset outputs to cmd_ready=1, op_valid=0, op_word=27'h7FFFFFF, tx_data_req=0, rx_data_valid=0, rx_data=0, done=0, err=0.

Configuration
REQ-020 SHALL, with W5300_SEQ_TIMEOUT_EN defined, end a CONF SSR poll or TX FSR retry after POLL_MAX unsuccessful reads with done=1, err=1, and no further ops.
REQ-021 SHALL, without W5300_SEQ_TIMEOUT_EN, poll indefinitely and contain no timeout counter.

Verification
REQ-022 SHALL cover CONF on sock_sel=2, SSR returns 0000, 0022 -> writes to 0x280/0x284/0x28A/0x298/0x282 with 0002/0140/1B58/05C0/0001, two SSR reads at 0x288, done, err=0.
REQ-023 SHALL cover TX on sock 0, tx_len=5, FSR={0001,0000}, dst_ip=C0A80102, dst_port=1F90 -> DIPR C0A8/0102, DPORTR 1F90, 3 TxFIFO writes with 3 tx_data_req pulses, WRSR2=0005, CR=0020.
REQ-024 SHALL cover TX with tx_len=100, FSR first {0000,0010} then {0000,0400} -> 4 FSR reads before the DIPR0 write.
REQ-025 SHALL cover RX with RSR={0000,0004} and FIFO data 1111, 2222 -> 2 rx_data_valid pulses carrying those values, then W 0x202=0040; RSR=0 -> done with no CR write.
REQ-026 SHALL cover sock_sel=7 with SOCKETS=4 -> done, err=1, zero ops; and rst_n low during a TxFIFO write, then op_valid=0 and cmd_ready=1 immediately.
REQ-027 SHALL cover, with W5300_SEQ_TIMEOUT_EN defined, POLL_MAX=3 and SSR stuck at 0000 -> exactly 3 SSR reads, then done with err=1.
